// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: issue controller between fetch and the decode register.
// A DEPTH-entry shift-register scoreboard tracks destination registers whose
// writes have not retired yet. An incoming instruction whose sources match a
// pending write is held (stall) and a bubble is sent to decode instead.
// A saturating counter records stall cycles for performance debug.
// Optional build macro: PIPE_HAZARD_ZERO_REG_EN (register 0 hard-wired zero).
module pipe_hazard_ctrl #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr_in,
  output logic             stall,
  output logic             issue,
  output logic [DEPTH-1:0] pend_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  // Instruction fields used by hazard detection
  logic       data_src;
  logic [4:0] ws_in;
  logic [4:0] rd1;
  logic [4:0] rd2;
  logic       unused_fields;

  assign data_src = instr_in[29];
  assign ws_in    = instr_in[25:21];
  assign rd1      = instr_in[20:16];
  assign rd2      = instr_in[15:11];
  // ALUOP and the low immediate bits do not influence hazards
  assign unused_fields = ^{instr_in[31:30], instr_in[28:26], instr_in[10:0]};

  // Scoreboard state: entry 0 is the youngest
  logic [DEPTH-1:0] v_q, v_d;
  logic [4:0]       ws_q [DEPTH];
  logic [4:0]       ws_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             new_v;

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  // Source/destination match; register 0 never matches when it is hard-wired
  function automatic logic src_match(input logic [4:0] ws, input logic [4:0] rd);
`ifdef PIPE_HAZARD_ZERO_REG_EN
    return (rd != 5'd0) && (ws == rd);
`else
    return ws == rd;
`endif
  endfunction

  // RAW hazard: any pending write matching RD1, or RD2 when it is a register operand
  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v_q[i] && (src_match(ws_q[i], rd1) || (!data_src && src_match(ws_q[i], rd2))))
        hz = 1'b1;
    end
  end

  assign stall = instr_valid & hz & ~reset;
  assign issue = instr_valid & ~hz & ~reset;

`ifdef PIPE_HAZARD_ZERO_REG_EN
  assign new_v = issue & (ws_in != 5'd0);
`else
  assign new_v = issue;
`endif

  // Next state: scoreboard shifts every cycle, a bubble enters as an invalid entry
  always_comb begin
    v_d      = v_q;
    ws_d     = ws_q;
    v_d[0]   = new_v;
    ws_d[0]  = issue ? ws_in : 5'd0;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]  = v_q[i-1];
      ws_d[i] = ws_q[i-1];
    end
    cnt_d = stall ? sat_inc(cnt_q) : cnt_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ws_q[i] <= 5'd0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      ws_q  <= ws_d;
    end
  end

  assign pend_valid = v_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (DEPTH=3, CNT_W=4). Expected per-cycle
// outputs are queued as stimulus is driven and compared when sampled.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [31:0] instr_in;
  logic       stall;
  logic       issue;
  logic [2:0] pend_valid;
  logic [3:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [31:0] ins;
    logic [8:0]  e;   // {stall, issue, pend_valid[2:0], stall_cnt[3:0]}
  } stim_t;

  logic [8:0] exp_q [$];

  pipe_hazard_ctrl #(.DEPTH(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_in(instr_in),
    .stall(stall), .issue(issue), .pend_valid(pend_valid), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic ds, input logic [4:0] ws,
                                     input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] w;
    w = 32'd0;
    w[29] = ds; w[25:21] = ws; w[20:16] = r1; w[15:11] = r2;
    return w;
  endfunction

  function automatic logic [8:0] ex(input logic s, input logic i,
                                    input logic [2:0] p, input logic [3:0] c);
    return {s, i, p, c};
  endfunction

  function automatic stim_t st(input logic r, input logic v, input logic [31:0] ins,
                               input logic [8:0] e);
    stim_t t;
    t.rst = r; t.v = v; t.ins = ins; t.e = e;
    return t;
  endfunction

  task automatic drive(input stim_t t);
    reset = t.rst; instr_valid = t.v; instr_in = t.ins;
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; instr_in = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t sq[$];
    logic [8:0] got, e;
    sq.push_back(st(1, 1, mk(0, 1, 10, 11), ex(0, 0, 3'b000, 0)));
    sq.push_back(st(0, 1, mk(0, 1, 10, 11), ex(0, 1, 3'b000, 0)));
    sq.push_back(st(0, 1, mk(0, 2, 12, 13), ex(0, 1, 3'b001, 0)));
    sq.push_back(st(0, 1, mk(0, 3, 14, 15), ex(0, 1, 3'b011, 0)));
    sq.push_back(st(1, 1, mk(0, 9, 1, 2),   ex(0, 0, 3'b111, 0)));
    sq.push_back(st(0, 1, mk(0, 9, 5, 6),   ex(0, 1, 3'b000, 0)));
    sq.push_back(st(0, 0, 32'd0,            ex(0, 0, 3'b001, 0)));
    foreach (sq[k]) begin
      drive(sq[k]); exp_q.push_back(sq[k].e);
      @(negedge clk);
      got = {stall, issue, pend_valid, stall_cnt}; e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset cyc%0d stall/issue/pend/cnt got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                 k, got[8], got[7], got[6:4], got[3:0], e[8], e[7], e[6:4], e[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw();
    stim_t sq[$];
    logic [8:0] got, e;
    do_reset();
    sq.push_back(st(0, 1, mk(0, 5, 10, 11), ex(0, 1, 3'b000, 0)));
    sq.push_back(st(0, 1, mk(0, 6, 5, 12),  ex(1, 0, 3'b001, 0)));
    sq.push_back(st(0, 1, mk(0, 6, 5, 12),  ex(1, 0, 3'b010, 1)));
    sq.push_back(st(0, 1, mk(0, 6, 5, 12),  ex(1, 0, 3'b100, 2)));
    sq.push_back(st(0, 1, mk(0, 6, 5, 12),  ex(0, 1, 3'b000, 3)));
    sq.push_back(st(0, 0, 32'd0,            ex(0, 0, 3'b001, 3)));
    foreach (sq[k]) begin
      drive(sq[k]); exp_q.push_back(sq[k].e);
      @(negedge clk);
      got = {stall, issue, pend_valid, stall_cnt}; e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL raw_rd1 cyc%0d stall/issue/pend/cnt got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                 k, got[8], got[7], got[6:4], got[3:0], e[8], e[7], e[6:4], e[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_datasource();
    stim_t sq[$];
    logic [8:0] got, e;
    do_reset();
    sq.push_back(st(0, 1, mk(0, 7, 10, 11), ex(0, 1, 3'b000, 0)));
    sq.push_back(st(0, 1, mk(1, 8, 20, 7),  ex(0, 1, 3'b001, 0)));
    sq.push_back(st(1, 0, 32'd0,            ex(0, 0, 3'b011, 0)));
    sq.push_back(st(0, 1, mk(0, 7, 10, 11), ex(0, 1, 3'b000, 0)));
    sq.push_back(st(0, 1, mk(0, 8, 20, 7),  ex(1, 0, 3'b001, 0)));
    sq.push_back(st(0, 1, mk(0, 8, 20, 7),  ex(1, 0, 3'b010, 1)));
    sq.push_back(st(0, 1, mk(0, 8, 20, 7),  ex(1, 0, 3'b100, 2)));
    sq.push_back(st(0, 1, mk(0, 8, 20, 7),  ex(0, 1, 3'b000, 3)));
    foreach (sq[k]) begin
      drive(sq[k]); exp_q.push_back(sq[k].e);
      @(negedge clk);
      got = {stall, issue, pend_valid, stall_cnt}; e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL datasource cyc%0d stall/issue/pend/cnt got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                 k, got[8], got[7], got[6:4], got[3:0], e[8], e[7], e[6:4], e[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t sq[$];
    logic [8:0] got, e;
    do_reset();
    sq.push_back(st(0, 1, mk(0, 1, 10, 10), ex(0, 1, 3'b000, 0)));
    sq.push_back(st(0, 1, mk(0, 2, 11, 11), ex(0, 1, 3'b001, 0)));
    sq.push_back(st(0, 1, mk(0, 3, 12, 12), ex(0, 1, 3'b011, 0)));
    sq.push_back(st(0, 1, mk(0, 4, 13, 13), ex(0, 1, 3'b111, 0)));
    sq.push_back(st(0, 0, 32'd0,            ex(0, 0, 3'b111, 0)));
    sq.push_back(st(0, 0, 32'd0,            ex(0, 0, 3'b110, 0)));
    foreach (sq[k]) begin
      drive(sq[k]); exp_q.push_back(sq[k].e);
      @(negedge clk);
      got = {stall, issue, pend_valid, stall_cnt}; e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL back_to_back cyc%0d stall/issue/pend/cnt got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                 k, got[8], got[7], got[6:4], got[3:0], e[8], e[7], e[6:4], e[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi_match();
    stim_t sq[$];
    logic [8:0] got, e;
    do_reset();
    sq.push_back(st(0, 1, mk(0, 9, 9, 9),   ex(0, 1, 3'b000, 0)));
    sq.push_back(st(0, 1, mk(0, 5, 10, 11), ex(0, 1, 3'b001, 0)));
    sq.push_back(st(0, 1, mk(0, 5, 12, 13), ex(0, 1, 3'b011, 0)));
    sq.push_back(st(0, 1, mk(0, 6, 5, 20),  ex(1, 0, 3'b111, 0)));
    sq.push_back(st(0, 1, mk(0, 6, 5, 20),  ex(1, 0, 3'b110, 1)));
    sq.push_back(st(0, 1, mk(0, 6, 5, 20),  ex(1, 0, 3'b100, 2)));
    sq.push_back(st(0, 1, mk(0, 6, 5, 20),  ex(0, 1, 3'b000, 3)));
    foreach (sq[k]) begin
      drive(sq[k]); exp_q.push_back(sq[k].e);
      @(negedge clk);
      got = {stall, issue, pend_valid, stall_cnt}; e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL multi_match cyc%0d stall/issue/pend/cnt got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                 k, got[8], got[7], got[6:4], got[3:0], e[8], e[7], e[6:4], e[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    stim_t sq[$];
    logic [8:0] got, e;
    do_reset();
    sq.push_back(st(0, 1, mk(0, 0, 10, 11), ex(0, 1, 3'b000, 0)));
`ifdef PIPE_HAZARD_ZERO_REG_EN
    sq.push_back(st(0, 1, mk(0, 13, 0, 12), ex(0, 1, 3'b000, 0)));
    sq.push_back(st(0, 0, 32'd0,            ex(0, 0, 3'b001, 0)));
`else
    sq.push_back(st(0, 1, mk(0, 13, 0, 12), ex(1, 0, 3'b001, 0)));
    sq.push_back(st(0, 1, mk(0, 13, 0, 12), ex(1, 0, 3'b010, 1)));
    sq.push_back(st(0, 1, mk(0, 13, 0, 12), ex(1, 0, 3'b100, 2)));
    sq.push_back(st(0, 1, mk(0, 13, 0, 12), ex(0, 1, 3'b000, 3)));
`endif
    foreach (sq[k]) begin
      drive(sq[k]); exp_q.push_back(sq[k].e);
      @(negedge clk);
      got = {stall, issue, pend_valid, stall_cnt}; e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL zero_reg cyc%0d stall/issue/pend/cnt got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                 k, got[8], got[7], got[6:4], got[3:0], e[8], e[7], e[6:4], e[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    stim_t sq[$];
    logic [8:0] got, e;
    int cnt;
    do_reset();
    cnt = 0;
    for (int p = 0; p < 6; p++) begin
      sq.push_back(st(0, 1, mk(0, 5, 10, 11), ex(0, 1, (p == 0) ? 3'b000 : 3'b001, 4'(cnt))));
      for (int s = 0; s < 3; s++) begin
        logic [2:0] pv;
        if (p == 0) pv = (s == 0) ? 3'b001 : (s == 1) ? 3'b010 : 3'b100;
        else        pv = (s == 0) ? 3'b011 : (s == 1) ? 3'b110 : 3'b100;
        sq.push_back(st(0, 1, mk(0, 6, 5, 12), ex(1, 0, pv, 4'(cnt))));
        cnt = (cnt >= 15) ? 15 : cnt + 1;
      end
      sq.push_back(st(0, 1, mk(0, 6, 5, 12), ex(0, 1, 3'b000, 4'(cnt))));
    end
    sq.push_back(st(0, 1, mk(0, 5, 10, 11), ex(0, 1, 3'b001, 15)));
    sq.push_back(st(0, 1, mk(0, 6, 5, 12),  ex(1, 0, 3'b011, 15)));
    sq.push_back(st(1, 1, mk(0, 6, 5, 12),  ex(0, 0, 3'b110, 15)));
    sq.push_back(st(0, 0, 32'd0,            ex(0, 0, 3'b000, 0)));
    foreach (sq[k]) begin
      drive(sq[k]); exp_q.push_back(sq[k].e);
      @(negedge clk);
      got = {stall, issue, pend_valid, stall_cnt}; e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL saturation cyc%0d stall/issue/pend/cnt got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                 k, got[8], got[7], got[6:4], got[3:0], e[8], e[7], e[6:4], e[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_raw();
    test_datasource();
    test_back_to_back();
    test_multi_match();
    test_zero_reg();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
